// File: rtl/lru_way_scheduler.sv
// lru_way_scheduler: per-set true-LRU ages for a set-associative cache; reports the hit way
// or the LRU victim two edges after each lookup and ages the set accordingly.
module lru_way_scheduler #(
  parameter int NWAYS   = 8,
  parameter int WAY_W   = 3,
  parameter int INDEX_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [INDEX_W-1:0] req_index,
  input  logic               req_hit,
  input  logic [WAY_W-1:0]   req_way,
  output logic               resp_valid,
  output logic [INDEX_W-1:0] resp_index,
  output logic               resp_hit,
  output logic [WAY_W-1:0]   resp_way
);
  typedef logic [NWAYS-1:0][WAY_W-1:0] ages_t;
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d, s1_index_q, s1_index_d, resp_index_q, resp_index_d, waddr;
  logic ready_q, ready_d, s1_valid_q, s1_valid_d, s1_hit_q, s1_hit_d;
  logic resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d, accept, we;
  logic [WAY_W-1:0] s1_way_q, s1_way_d, resp_way_q, resp_way_d, victim, touched, old_age;
  ages_t s1_ages_q, s1_ages_d, new_ages, init_ages, wdata;
  ages_t mem [2**INDEX_W];
  always_comb begin
    victim    = '0;
    init_ages = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (s1_ages_q[w] == WAY_W'(NWAYS-1)) victim = WAY_W'(w);
      init_ages[w] = WAY_W'(w);
    end
    touched = s1_hit_q ? s1_way_q : victim;
    old_age = s1_ages_q[touched];
    new_ages = '0;
    for (int w = 0; w < NWAYS; w++)
      new_ages[w] = (WAY_W'(w) == touched) ? '0 :
                    (s1_ages_q[w] < old_age) ? s1_ages_q[w] + 1'b1 : s1_ages_q[w];
    accept  = req_valid & ready_q;
    state_d = (state_q == INIT && cnt_q == '1) ? RUN : state_q;
    cnt_d   = (state_q == INIT) ? cnt_q + 1'b1 : cnt_q;
    ready_d = (state_d == RUN);
    s1_valid_d = accept;
    s1_index_d = accept ? req_index : s1_index_q;
    s1_hit_d   = accept ? req_hit : s1_hit_q;
    s1_way_d   = accept ? req_way : s1_way_q;
    // a report to the set being written back this edge must see the updated ages
    s1_ages_d  = !accept ? s1_ages_q :
                 (s1_valid_q && s1_index_q == req_index) ? new_ages : mem[req_index];
    resp_valid_d = s1_valid_q;
    resp_index_d = s1_valid_q ? s1_index_q : resp_index_q;
    resp_hit_d   = s1_valid_q ? s1_hit_q : resp_hit_q;
    resp_way_d   = s1_valid_q ? touched : resp_way_q;
    we    = (state_q == INIT) || s1_valid_q;
    waddr = (state_q == INIT) ? cnt_q : s1_index_q;
    wdata = (state_q == INIT) ? init_ages : new_ages;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_index_q   <= '0;
      s1_hit_q     <= 1'b0;
      s1_way_q     <= '0;
      s1_ages_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_index_q <= '0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      s1_valid_q   <= s1_valid_d;
      s1_index_q   <= s1_index_d;
      s1_hit_q     <= s1_hit_d;
      s1_way_q     <= s1_way_d;
      s1_ages_q    <= s1_ages_d;
      resp_valid_q <= resp_valid_d;
      resp_index_q <= resp_index_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_index = resp_index_q;
  assign resp_hit   = resp_hit_q;
  assign resp_way   = resp_way_q;
endmodule

// File: tb/tb_lru_way_scheduler.sv
// tb_lru_way_scheduler: directed and random lookups checked against a per-set recency-list model.
module tb_lru_way_scheduler;
  localparam int NWAYS = 8, WAY_W = 3, INDEX_W = 10, NSETS = 2**INDEX_W;
  logic clk = 0, rst = 1, req_valid = 0, req_hit = 0;
  logic req_ready, resp_valid, resp_hit;
  logic [INDEX_W-1:0] req_index = '0, resp_index;
  logic [WAY_W-1:0] req_way = '0, resp_way;
  int total = 0, bad = 0, cyc = 0;
  int lru [NSETS][NWAYS];
  typedef struct {int idx; int hit; int way; int due;} exp_t;
  exp_t exp_q[$];

  lru_way_scheduler #(.NWAYS(NWAYS), .WAY_W(WAY_W), .INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_hit(req_hit), .req_way(req_way),
    .resp_valid(resp_valid), .resp_index(resp_index), .resp_hit(resp_hit), .resp_way(resp_way));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // recency list per set: position 0 is most recent, last position is the victim
  function automatic void model_init();
    for (int s = 0; s < NSETS; s++)
      for (int i = 0; i < NWAYS; i++) lru[s][i] = i;
  endfunction

  task automatic do_req(input int idx, input int hit, input int way);
    exp_t e;
    int t, p;
    t = hit ? way : lru[idx][NWAYS-1];
    p = 0;
    for (int i = 0; i < NWAYS; i++) if (lru[idx][i] == t) p = i;
    for (int i = p; i > 0; i--) lru[idx][i] = lru[idx][i-1];
    lru[idx][0] = t;
    e.idx = idx; e.hit = hit; e.way = t; e.due = cyc + 2;
    exp_q.push_back(e);
    req_valid = 1; req_index = INDEX_W'(idx); req_hit = hit[0]; req_way = WAY_W'(way);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_init();
    int early = 0;
    for (int k = 1; k <= NSETS; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_index = INDEX_W'($urandom);
      req_hit = 1'($urandom); req_way = WAY_W'($urandom);
      @(posedge clk); #1;
      if (k < NSETS && req_ready) early++;
    end
    req_valid = 0;
    chk("init_ready_early", early, 0);
    chk("init_ready_high", req_ready, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("resp_index", resp_index, e.idx);
        chk("resp_hit", resp_hit, e.hit);
        chk("resp_way", resp_way, e.way);
        chk("resp_latency", cyc, e.due);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_index", resp_index, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_way", resp_way, 0);
    rst = 0;
    model_init();
    wait_init();
    idle(2);
    for (int i = 0; i < 9; i++) do_req(5, 0, 0);
    do_req(9, 1, 3);
    for (int i = 0; i < 8; i++) do_req(9, 0, 0);
    do_req(12, 0, 0); do_req(12, 0, 0);
    do_req(40, 0, 0); do_req(41, 0, 0); do_req(40, 0, 0); do_req(41, 0, 0);
    idle(3);
    for (int i = 0; i < 3; i++) do_req(20, 1, 0);
    do_req(20, 0, 0);
    idle(2);
    do_req(20, 1, 5);
    do_req(30, 0, 0);
    rst = 1;
    #1;
    chk("async_ready", req_ready, 0);
    chk("async_resp_valid", resp_valid, 0);
    chk("async_resp_index", resp_index, 0);
    chk("async_resp_hit", resp_hit, 0);
    chk("async_resp_way", resp_way, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    model_init();
    wait_init();
    do_req(30, 0, 0);
    idle(3);
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else do_req(100 + $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, NWAYS-1));
    end
    idle(4);
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
